cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
AXI4 read-burst refill engine sitting between the cache miss path and the memory-side AXI read channels. On a cache miss it issues one INCR burst for the whole line. It then forwards each returned word to the cache fill port (mem_addr / mem_data_in / mem_data_valid / mem_last), pacing beats to the cache's one-cycle-pulse contract. It also flags protocol and response errors.

Parameters:
LINE_BYTES, 128, line size in bytes; power of 2, 8..1024; BEATS = LINE_BYTES/4, beat counter width = log2(BEATS)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
miss_req  in  1  cache requests line fill; level, held until miss_ack
miss_addr  in  32  CPU address of missing access
miss_ack  out  1  one-cycle pulse: request accepted
busy  out  1  high whenever state != IDLE
mem_addr  out  32  byte address of current fill word
mem_data_in  out  32  fill word to cache
mem_data_valid  out  1  fill word valid, one-cycle pulse
mem_last  out  1  final fill word, coincident with mem_data_valid
fill_err  out  1  one-cycle pulse with mem_last if burst had an error
m_axi_araddr  out  32  line-aligned burst address
m_axi_arlen  out  8  BEATS-1
m_axi_arsize  out  3  constant 3'b010
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready

Behaviour:
- Reset (reset_n=0 at edge), all registered state cleared:
  - state=IDLE.
  - Outputs 0: miss_ack, mem_addr, mem_data_in, mem_data_valid, mem_last, fill_err, arvalid, araddr, rready.
  - Beat counter 0; error flag 0.
- Reset mid-burst: same clearing, with no completion pulse. The outstanding AXI transaction is abandoned; the memory side shares this reset.
- FSM states IDLE, AR, DATA, DRAIN.
- IDLE:
  - On miss_req=1: latch line = {miss_addr[31:log2(LINE_BYTES)], zeros}.
  - Next cycle: miss_ack=1 for that one cycle, araddr=line, mem_addr=line, arvalid=1, counter=0, err=0; go to AR.
- AR:
  - arvalid held high; araddr/arlen stable until arready.
  - On arvalid&&arready: arvalid=0 next cycle; go to DATA. rready is never high in AR.
- DATA:
  - rready = !mem_data_valid. At most one beat every 2 cycles, so mem_data_valid is never high on consecutive cycles.
  - Beat accepted (rvalid&&rready): next cycle mem_data_valid=1, mem_data_in=rdata. mem_addr holds that beat's address (line + 4*counter) during the valid cycle.
  - mem_addr increments by 4 on the cycle after each valid pulse, except after the final beat: it holds at the last beat address until the next miss.
  - rresp[1]=1 (SLVERR/DECERR) on any beat sets the error flag. The data is still forwarded.
  - Normal end: beat with counter==BEATS-1 and rlast=1 → mem_last=1 with its valid pulse; fill_err = error flag; go to IDLE.
  - Early rlast (counter<BEATS-1): that beat is forwarded with mem_last=1 and fill_err=1; go to IDLE.
  - Late rlast: beat BEATS-1 with rlast=0 → forwarded with mem_last=1 and fill_err=1; go to DRAIN.
- DRAIN:
  - rready=1; beats discarded, no mem_data_valid.
  - On accepted beat with rlast=1 → IDLE.
  - busy stays high; a new miss_req waits.
- Arithmetic: counter wraps never (terminates at BEATS-1); mem_addr adds in 32 bits, staying within the line.
- miss_req while busy: ignored until IDLE; no miss_ack.
- Back-to-back misses: miss_req held in the IDLE cycle after completion is accepted normally.
- Minimum latency, miss_req to first mem_data_valid: 4 cycles (arready and rvalid immediate).

Test Plan:
1. Reset held 2 cycles, then released with no miss → all outputs 0, busy=0, no arvalid for 20 cycles.
2. miss_addr=0x0001_23C4, arready and rvalid always 1, rresp=0, rlast on beat 32:
   - AR: araddr=0x0001_2380, arlen=31, arsize=2, arburst=1.
   - Fill: 32 valid pulses, one every 2 cycles; mem_addr 0x12380..0x123FC.
   - End: mem_last with addr 0x123FC, fill_err=0, busy=0 afterwards.
3. arready withheld 5 cycles → arvalid/araddr stable throughout, rready=0 until handshake, fill completes as in 2.
4. rresp=2'b10 on beat 10 → all 32 beats forwarded, fill_err=1 only with mem_last.
5. rlast on beat 20 → mem_last on 20th pulse with mem_addr=line+0x4C, fill_err=1, state IDLE next cycle.
6. Reset asserted during beat 15, then a new miss at 0x8000_0004 → after reset, valid=0 and mem_addr=0. The new fill reaches araddr=0x8000_0000 and completes with fill_err=0.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - AXI4 read-burst cache line refill engine
// One INCR burst per miss; returned words are paced onto the cache fill port at most every other cycle.
module cache_refill_ctrl #(
  parameter int LINE_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        miss_req,
  input  logic [31:0] miss_addr,
  output logic        miss_ack,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_data_valid,
  output logic        mem_last,
  output logic        fill_err,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  localparam int BEATS = LINE_BYTES / 4;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] LINE_MASK = ~32'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, AR, DATA, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      data_q, data_d;
  logic             arvalid_q, arvalid_d;
  logic             ack_q, ack_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             ferr_q, ferr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_hs;
  logic             beat_err;
  logic             unused_rresp0;

  // Holding rready low during the valid pulse guarantees a one-cycle gap between fill words.
  assign m_axi_rready  = (state_q == DRAIN) || ((state_q == DATA) && !valid_q);
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign beat_err      = err_q | m_axi_rresp[1];
  assign unused_rresp0 = m_axi_rresp[0];

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    arvalid_d  = arvalid_q;
    ack_d      = 1'b0;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    ferr_d     = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;

    if (valid_q && !last_q) begin
      mem_addr_d = mem_addr_q + 32'd4;
      cnt_d      = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          ack_d      = 1'b1;
          araddr_d   = miss_addr & LINE_MASK;
          mem_addr_d = miss_addr & LINE_MASK;
          arvalid_d  = 1'b1;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = AR;
        end
      end
      AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          valid_d = 1'b1;
          data_d  = m_axi_rdata;
          err_d   = beat_err;
          if (cnt_q == LAST_BEAT) begin
            last_d = 1'b1;
            if (m_axi_rlast) begin
              ferr_d  = beat_err;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = DRAIN;
            end
          end else if (m_axi_rlast) begin
            last_d  = 1'b1;
            ferr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (r_hs && m_axi_rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      arvalid_q  <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      ferr_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      arvalid_q  <= arvalid_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      ferr_q     <= ferr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign miss_ack       = ack_q;
  assign busy           = (state_q != IDLE);
  assign mem_addr       = mem_addr_q;
  assign mem_data_in    = data_q;
  assign mem_data_valid = valid_q;
  assign mem_last       = last_q;
  assign fill_err       = ferr_q;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = 8'(BEATS - 1);
  assign m_axi_arsize   = 3'b010;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arvalid  = arvalid_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed bench for cache_refill_ctrl
// Burst-level reference model plus literal expectations for the headline fills.
module tb_cache_refill_ctrl;
  localparam int LINE_BYTES = 128;
  localparam int BEATS = LINE_BYTES / 4;

  logic        clk;
  logic        reset_n;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ack;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_last;
  logic        fill_err;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  cache_refill_ctrl #(.LINE_BYTES(LINE_BYTES)) dut (
    .clk(clk), .reset_n(reset_n),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack), .busy(busy),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .mem_last(mem_last), .fill_err(fill_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // memory-side configuration for the current burst
  int          cfg_ard = 0;
  int          cfg_rl = BEATS;
  int          cfg_eb = 0;
  logic [31:0] cur_line = 32'd0;

  // slave progress, advanced at observed handshakes
  logic s_active = 1'b0;
  int   s_sent = 0;
  int   ar_cyc = 0;

  // reference model state
  logic [65:0] exp_q[$];
  logic [65:0] e;
  logic        m_busy = 1'b0;
  logic        m_drain = 1'b0;
  logic        m_inburst = 1'b0;
  logic        m_err = 1'b0;
  int          m_k = 0;
  int          k = 0;
  logic        lst;
  logic        fe;
  int          total_pulses = 0;
  logic [31:0] last_araddr = 32'd0;

  logic        rst_prev_low = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_arv = 1'b0;
  logic        prev_arr = 1'b0;
  logic [31:0] prev_araddr = 32'd0;
  logic        prev_ack = 1'b0;
  logic        prev_busy = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] line, input int idx);
    return 32'hC0DE_0000 ^ line ^ (32'(idx) << 20) ^ 32'(idx);
  endfunction

  // memory-side driver: inputs change just after the active edge
  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = 32'd0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'b00;
        ar_cyc        = 0;
      end else begin
        if (m_axi_arvalid) begin
          m_axi_arready = (ar_cyc >= cfg_ard);
          ar_cyc++;
        end else begin
          m_axi_arready = 1'b0;
          ar_cyc = 0;
        end
        m_axi_rvalid = s_active && (s_sent < cfg_rl);
        m_axi_rdata  = beat_data(cur_line, s_sent);
        m_axi_rlast  = m_axi_rvalid && (s_sent + 1 == cfg_rl);
        m_axi_rresp  = (m_axi_rvalid && (s_sent + 1 == cfg_eb)) ? 2'b10 : 2'b00;
      end
    end
  end

  // compare process: model update and output checks on the falling edge
  always @(negedge clk) begin
    if (!reset_n) begin
      if (rst_prev_low)
        chk("reset_outputs",
            128'({miss_ack, busy, mem_addr, mem_data_in, mem_data_valid, mem_last, fill_err,
                  m_axi_arvalid, m_axi_araddr, m_axi_rready}), 128'(0));
      rst_prev_low = 1'b1;
      exp_q.delete();
      m_busy = 1'b0; m_drain = 1'b0; m_inburst = 1'b0; m_err = 1'b0; m_k = 0;
      s_active = 1'b0; s_sent = 0;
      prev_valid = 1'b0; prev_arv = 1'b0; prev_arr = 1'b0; prev_ack = 1'b0; prev_busy = 1'b0;
    end else begin
      rst_prev_low = 1'b0;
      if (mem_data_valid && mem_last && !m_drain) m_busy = 1'b0;
      if (miss_ack) m_busy = 1'b1;
      chk("busy", 128'(busy), 128'(m_busy));
      if (mem_data_valid) begin
        chk("valid_gap", 128'(prev_valid), 128'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("fill_word", 128'({mem_addr, mem_data_in, mem_last, fill_err}), 128'(e));
        end
        total_pulses++;
      end else begin
        chk("idle_strobes", 128'({mem_last, fill_err}), 128'(0));
      end
      if (miss_ack) chk("ack_after_idle", 128'({prev_ack, prev_busy}), 128'(0));
      chk("rready_in_ar", 128'(m_axi_arvalid && m_axi_rready), 128'(0));
      if (prev_arv && !prev_arr)
        chk("ar_hold", 128'({m_axi_arvalid, m_axi_araddr}), 128'({1'b1, prev_araddr}));
      if (m_axi_arvalid && m_axi_arready) begin
        chk("ar_fields", 128'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}),
            128'({cur_line, 8'(BEATS - 1), 3'b010, 2'b01}));
        last_araddr = m_axi_araddr;
        m_inburst = 1'b1; m_k = 0; m_err = 1'b0; m_drain = 1'b0;
        s_active = 1'b1; s_sent = 0;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        if (m_drain) begin
          if (m_axi_rlast) begin
            m_drain = 1'b0;
            m_busy = 1'b0;
          end
        end else if (m_inburst) begin
          k = m_k;
          m_k++;
          m_err = m_err | m_axi_rresp[1];
          lst = m_axi_rlast || (k == BEATS - 1);
          fe = lst && (m_err || (m_axi_rlast != (k == BEATS - 1)));
          exp_q.push_back({cur_line + 32'(4 * k), m_axi_rdata, lst, fe});
          if (lst) begin
            m_inburst = 1'b0;
            if (!m_axi_rlast) m_drain = 1'b1;
          end
        end
        s_sent++;
        if (m_axi_rlast) s_active = 1'b0;
      end
      prev_valid = mem_data_valid;
      prev_arv = m_axi_arvalid;
      prev_arr = m_axi_arready;
      prev_araddr = m_axi_araddr;
      prev_ack = miss_ack;
      prev_busy = busy;
    end
  end

  task automatic run_fill(input logic [31:0] addr, input int ard, input int rl, input int eb,
                          input int exp_pulses, input logic exp_err, input logic b2b,
                          output logic [31:0] last_addr);
    int start;
    logic got;
    cfg_ard = ard;
    cfg_rl = rl;
    cfg_eb = eb;
    cur_line = addr & ~32'(LINE_BYTES - 1);
    start = total_pulses;
    miss_addr = addr;
    miss_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      got = miss_ack;
    end
    chk("miss_ack_seen", 128'(got), 128'(1));
    miss_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); #1;
      got = mem_data_valid && mem_last;
    end
    chk("mem_last_seen", 128'(got), 128'(1));
    last_addr = mem_addr;
    chk("pulse_count", 128'(total_pulses - start), 128'(exp_pulses));
    chk("fill_err_end", 128'(fill_err), 128'(exp_err));
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    if (!b2b) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk); #1;
        got = !busy;
      end
      chk("back_to_idle", 128'(got), 128'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] la;
    int start;
    logic got;
    reset_n = 1'b0;
    miss_req = 1'b0;
    miss_addr = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("idle_quiet",
          128'({miss_ack, busy, m_axi_arvalid, m_axi_rready, mem_data_valid, mem_last, fill_err,
                mem_addr, mem_data_in, m_axi_araddr}), 128'(0));
    end

    run_fill(32'h0001_23C4, 0, 32, 0, 32, 1'b0, 1'b0, la);
    chk("t2_araddr", 128'(last_araddr), 128'(32'h0001_2380));
    chk("t2_last_addr", 128'(la), 128'(32'h0001_23FC));

    run_fill(32'h00AB_C010, 5, 32, 0, 32, 1'b0, 1'b0, la);
    chk("t3_araddr", 128'(last_araddr), 128'(32'h00AB_C000));
    chk("t3_last_addr", 128'(la), 128'(32'h00AB_C07C));

    run_fill(32'h0000_5000, 0, 32, 10, 32, 1'b1, 1'b0, la);
    chk("t4_last_addr", 128'(la), 128'(32'h0000_507C));

    run_fill(32'h0001_23C4, 0, 20, 0, 20, 1'b1, 1'b0, la);
    chk("t5_early_last_addr", 128'(la), 128'(32'h0001_23CC));

    run_fill(32'h0000_7F00, 0, 34, 0, 32, 1'b1, 1'b0, la);
    chk("late_last_addr", 128'(la), 128'(32'h0000_7F7C));

    run_fill(32'h0000_1234, 0, 32, 0, 32, 1'b0, 1'b1, la);
    chk("b2b_first_araddr", 128'(last_araddr), 128'(32'h0000_1200));
    run_fill(32'h0000_2240, 0, 32, 0, 32, 1'b0, 1'b0, la);
    chk("b2b_second_araddr", 128'(last_araddr), 128'(32'h0000_2200));

    cfg_ard = 0; cfg_rl = 32; cfg_eb = 0;
    cur_line = 32'h0004_0000;
    start = total_pulses;
    miss_addr = 32'h0004_0008;
    miss_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      got = miss_ack;
    end
    chk("t6_ack_seen", 128'(got), 128'(1));
    miss_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      got = (total_pulses - start == 15);
    end
    chk("t6_beat15_seen", 128'(got), 128'(1));
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
    end
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("t6_post_reset", 128'({mem_data_valid, busy, mem_addr}), 128'(0));
    run_fill(32'h8000_0004, 0, 32, 0, 32, 1'b0, 1'b0, la);
    chk("t6_new_araddr", 128'(last_araddr), 128'(32'h8000_0000));
    chk("t6_new_last_addr", 128'(la), 128'(32'h8000_007C));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
